// File: rtl/rram_adc_accumulator.sv
// rram_adc_accumulator
// Collects the column ADC code stream of an in-memory-compute run and
// accumulates a programmable number of samples per column, saturating at the
// accumulator width. The per-column sums and the run status are readable over
// a Wishbone slave window. busy/done/overflow report run progress.
module rram_adc_accumulator #(
  parameter int          ADC_W     = 3,
  parameter int          ACC_W     = 8,
  parameter int          NUM_COL   = 4,
  parameter int          COL_W     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        num_samples,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc_code,
  input  logic [COL_W-1:0]  adc_col,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  input  logic              wishbone_cyc,
  input  logic              wishbone_stb,
  input  logic              wishbone_we,
  input  logic [31:0]       wishbone_address_bus,
  input  logic [31:0]       wishbone_data_in,
  output logic              wishbone_ack,
  output logic [31:0]       wishbone_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Sample counters must hold 16, so they are one bit wider than num_samples.
  localparam int CNT_W = 5;
  localparam int SLOTS = 2 ** COL_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  logic [1:0]       state_r;
  logic [CNT_W-1:0] n_r;
  logic [ACC_W-1:0] acc_r [NUM_COL];
  logic [CNT_W-1:0] cnt_r [NUM_COL];
  logic             done_r;
  logic             overflow_r;
  logic             ack_r;
  logic [31:0]      dout_r;

  logic [CNT_W-1:0] n_load_s;
  logic [SLOTS-1:0] col_exists_s;
  logic             accept_s;
  logic [ACC_W:0]   sum_s;
  logic [CNT_W-1:0] cnt_nx_s [NUM_COL];
  logic             all_full_s;

  logic             wb_hit_s;
  logic             wb_req_s;
  logic [7:0]       wb_off_s;
  logic [5:0]       wb_word_s;
  logic [31:0]      rdata_s;
  logic             clear_s;
  logic             unused_wdata;

  assign busy              = (state_r == ACCUM);
  assign done              = done_r;
  assign overflow          = overflow_r;
  assign wishbone_ack      = ack_r;
  assign wishbone_data_out = dout_r;

  // Only bit 0 of write data has meaning (status clear).
  assign unused_wdata = ^wishbone_data_in[31:1];

  // A sample count of 0 stands for the full 16 samples.
  always_comb begin
    if (num_samples == 4'd0) begin
      n_load_s = 5'd16;
    end else begin
      n_load_s = {1'b0, num_samples};
    end
  end

  // Flags which column codes map to a real accumulator.
  always_comb begin
    col_exists_s = '0;
    for (int i = 0; i < SLOTS; i++) begin
      col_exists_s[i] = (i < NUM_COL) ? 1'b1 : 1'b0;
    end
  end

  // Sample acceptance: start always wins, full columns and absent columns drop.
  always_comb begin
    accept_s = 1'b0;
    sum_s    = '0;
    if ((state_r == ACCUM) && adc_valid && !start && col_exists_s[adc_col]) begin
      accept_s = (cnt_r[adc_col] < n_r);
      sum_s    = {1'b0, acc_r[adc_col]} + {{(ACC_W + 1 - ADC_W){1'b0}}, adc_code};
    end else begin
      accept_s = 1'b0;
      sum_s    = '0;
    end
  end

  // Looks ahead at the counters after this cycle to spot the run's last sample.
  always_comb begin
    all_full_s = 1'b1;
    for (int c = 0; c < NUM_COL; c++) begin
      if (accept_s && (adc_col == COL_W'(c))) begin
        cnt_nx_s[c] = cnt_r[c] + 5'd1;
      end else begin
        cnt_nx_s[c] = cnt_r[c];
      end
      all_full_s = all_full_s & (cnt_nx_s[c] == n_r);
    end
  end

  // Wishbone decode: the window is the 256 bytes sharing BASE_ADDR[31:8].
  always_comb begin
    wb_off_s  = wishbone_address_bus[7:0];
    wb_word_s = wishbone_address_bus[7:2];
    wb_hit_s  = wishbone_cyc & wishbone_stb &
                (wishbone_address_bus[31:8] == BASE_ADDR[31:8]);
    // A request is taken only while ack is low, so a held strobe alternates.
    wb_req_s  = wb_hit_s & ~ack_r;
    clear_s   = wb_req_s & wishbone_we & (wb_off_s == 8'h00) & wishbone_data_in[0];
  end

  // Read mux: status at word 0, accumulators at words 1..NUM_COL, else zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (wb_off_s[1:0] != 2'b00) begin
      rdata_s = 32'h0000_0000;
    end else if (wb_word_s == 6'd0) begin
      rdata_s = {29'd0, overflow_r, done_r, busy};
    end else if (wb_word_s <= 6'(NUM_COL)) begin
      rdata_s = 32'(acc_r[wb_word_s[COL_W-1:0] - COL_W'(1)]);
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Run state machine, accumulators, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      n_r        <= 5'd16;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        acc_r[c] <= '0;
        cnt_r[c] <= '0;
      end
    end else if (start) begin
      state_r    <= ACCUM;
      n_r        <= n_load_s;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        acc_r[c] <= '0;
        cnt_r[c] <= '0;
      end
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            if (sum_s[ACC_W]) begin
              acc_r[adc_col] <= ACC_MAX;
              overflow_r     <= 1'b1;
            end else begin
              acc_r[adc_col] <= sum_s[ACC_W-1:0];
            end
            cnt_r[adc_col] <= cnt_nx_s[adc_col];
            if (all_full_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        IDLE: begin
          state_r <= IDLE;
        end
        DONE: begin
          if (clear_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // A status clear wipes the sticky flags; it loses only to start.
      if (clear_s) begin
        done_r     <= 1'b0;
        overflow_r <= 1'b0;
      end
    end
  end

  // One-cycle ack with registered read data; data is zero whenever ack is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r  <= 1'b0;
      dout_r <= 32'h0000_0000;
    end else if (wb_req_s) begin
      ack_r  <= 1'b1;
      dout_r <= rdata_s;
    end else begin
      ack_r  <= 1'b0;
      dout_r <= 32'h0000_0000;
    end
  end

endmodule
